// File: rtl/cpu_checker_arbiter.sv
// Shares one cpu_checker between two trace sources: a granted source's line is
// buffered from '^' to '#', then replayed as one gap-free burst and reported.
module cpu_checker_arbiter #(
  parameter int          MAX_LEN      = 64,
  parameter logic [15:0] FREQ_DEFAULT = 16'd2,
  parameter int          AW           = $clog2(MAX_LEN) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [15:0] freq_in,
  input  logic [7:0]  src0_char,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [7:0]  src1_char,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [7:0]  chk_char,
  output logic [15:0] chk_freq,
  input  logic [1:0]  chk_format_type,
  input  logic [3:0]  chk_error_code,
  output logic        res_valid,
  output logic        res_src,
  output logic [1:0]  res_format,
  output logic [3:0]  res_error,
  output logic        res_overflow
);

  localparam int IW = $clog2(MAX_LEN);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] REPORT  = 3'd4;

  localparam logic [7:0] CARET = 8'h5E;
  localparam logic [7:0] HASH  = 8'h23;

  logic [2:0]    state;
  logic          grant;
  logic          last_grant;
  logic          pick;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [7:0]    line_buf [MAX_LEN];
  logic [7:0]    in_char;
  logic          in_valid;
  logic          take;
  logic          buf_we;
  logic [IW-1:0] buf_addr;

  // The source that did not win last time has priority; a lone requester always wins.
  assign pick = (src0_valid && src1_valid) ? ~last_grant : src1_valid;

  assign in_char  = grant ? src1_char : src0_char;
  assign in_valid = grant ? src1_valid : src0_valid;
  assign take     = (state == COLLECT) && in_valid;

  assign src0_ready = (state == COLLECT) && !grant;
  assign src1_ready = (state == COLLECT) && grant;
  assign res_valid  = (state == REPORT);

  assign rd_next = rd_ptr + AW'(1);

  // A '^' always restarts the line at slot 0; anything before the first '^' is dropped.
  assign buf_we   = take && ((in_char == CARET) || (wr_ptr != '0));
  assign buf_addr = (in_char == CARET) ? '0 : wr_ptr[IW-1:0];

  always_ff @(posedge clk) begin
    if (buf_we) line_buf[buf_addr] <= in_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      chk_char     <= 8'h00;
      chk_freq     <= FREQ_DEFAULT;
      res_src      <= 1'b0;
      res_format   <= 2'b00;
      res_error    <= 4'b0000;
      res_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) chk_freq <= freq_in;
          if (src0_valid || src1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= COLLECT;
          end
        end

        COLLECT: begin
          if (take) begin
            if (in_char == CARET) begin
              wr_ptr <= AW'(1);
            end else if (wr_ptr != '0) begin
              wr_ptr <= wr_ptr + AW'(1);
              if (in_char == HASH) begin
                // Preload the first char so the burst starts the cycle after '#'.
                state    <= SEND;
                rd_ptr   <= '0;
                chk_char <= line_buf[0];
              end else if (wr_ptr == AW'(MAX_LEN - 1)) begin
                state        <= REPORT;
                res_src      <= grant;
                res_overflow <= 1'b1;
                res_format   <= 2'b00;
                res_error    <= 4'b0000;
              end
            end
          end
        end

        SEND: begin
          rd_ptr <= rd_next;
          if (rd_next == wr_ptr) begin
            chk_char <= 8'h00;
            state    <= WAIT;
          end else begin
            chk_char <= line_buf[rd_next[IW-1:0]];
          end
        end

        WAIT: begin
          res_format   <= chk_format_type;
          res_error    <= chk_error_code;
          res_overflow <= 1'b0;
          res_src      <= grant;
          state        <= REPORT;
        end

        REPORT: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
